fp_pipe_arbiter: RTL and testbench

FP_PIPE_ARBITER -- requirements
Module: fp_pipe_arbiter

---
 rtl/fp_pipe_arbiter.sv | 116 +++++++++++
 tb/tb_fp_pipe_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pipe_arbiter.sv
// Round-robin arbiter in front of a shared, fixed-latency pipelined FP unit.
// Grants one requester per cycle, registers its operands into the FP unit,
// and tracks each operation's owner in a tag pipeline so the result can be
// steered back as a one-hot strobe. A hold input freezes the whole path.
module fp_pipe_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_dataa,
  input  logic [32*NUM_REQ-1:0]   req_datab,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             fu_dataa,
  output logic [31:0]             fu_datab,
  output logic                    fu_clk_en,
  input  logic [31:0]             fu_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [4:0]              in_flight
);

  // One tag slot per enabled edge between acceptance and result capture:
  // the operand register plus LATENCY FP unit stages.
  localparam int unsigned Depth = LATENCY + 1;

  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;
  logic             retire;
  logic [Depth-1:0] tag_valid_q;
  logic [IDX_W-1:0] tag_idx_q [Depth];
  logic [31:0]      cand;
  logic [IDX_W-1:0] cand_idx;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    cand_idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_grant_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Grant is suppressed while frozen or in reset; retire only on a moving pipe.
  always_comb begin
    accept    = grant_found & ~hold & ~reset;
    req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    fu_clk_en = ~hold;
    retire    = tag_valid_q[Depth-1] & ~hold;
  end

  // Arbitration pointer and operand registers feeding the FP unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      fu_dataa     <= '0;
      fu_datab     <= '0;
    end else if (accept) begin
      last_grant_q <= grant_idx;
      fu_dataa     <= req_dataa[grant_idx*32 +: 32];
      fu_datab     <= req_datab[grant_idx*32 +: 32];
    end
  end

  // Tag pipeline mirrors the FP unit; it advances only when the unit is enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= '0;
    end else if (!hold) begin
      tag_valid_q  <= {tag_valid_q[Depth-2:0], accept};
      tag_idx_q[0] <= grant_idx;
      for (int unsigned k = 1; k < Depth; k++) begin
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  // Capture the retiring result and strobe its owner for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= retire ? (NUM_REQ'(1) << tag_idx_q[Depth-1]) : '0;
      if (retire) begin
        rsp_data <= fu_result;
      end
    end
  end

  // Outstanding-operation counter; accept and retire together cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      unique case ({accept, retire})
        2'b10:   in_flight <= in_flight + 5'd1;
        2'b01:   in_flight <= in_flight - 5'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_pipe_arbiter.sv
// Testbench for fp_pipe_arbiter: hand-written grant table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_fp_pipe_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 5;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  hold;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [32*NUM_REQ-1:0] req_datab;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           fu_dataa;
  logic [31:0]           fu_datab;
  logic                  fu_clk_en;
  logic [31:0]           fu_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic [4:0]            in_flight;

  fp_pipe_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LATENCY(LAT),
    .IDX_W  (IDX_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .req_valid(req_valid),
    .req_dataa(req_dataa),
    .req_datab(req_datab),
    .req_ready(req_ready),
    .fu_dataa (fu_dataa),
    .fu_datab (fu_datab),
    .fu_clk_en(fu_clk_en),
    .fu_result(fu_result),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  // Stand-in FP operation; any deterministic function of the operands works.
  function automatic logic [31:0] fu_op(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  // FP unit model: LAT-stage pipe advancing on enabled edges.
  logic [31:0] fu_pipe [LAT];
  always @(posedge clk) begin
    if (fu_clk_en) begin
      fu_pipe[0] <= fu_op(fu_dataa, fu_datab);
      for (int k = 1; k < LAT; k++) fu_pipe[k] <= fu_pipe[k-1];
    end
  end
  assign fu_result = fu_pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: pending ops with count of enabled edges since acceptance.
  int          m_last;
  int          q_idx [$];
  logic [31:0] q_res [$];
  int          q_cnt [$];
  logic [3:0]  exp_rv;
  logic [31:0] exp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_pick();
    if (reset || hold) return -1;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int c;
      c = (m_last + i) % NUM_REQ;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive(input logic r, input logic h, input logic [3:0] v);
    reset     = r;
    hold      = h;
    req_valid = v;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_dataa[32*k +: 32] = $urandom();
      req_datab[32*k +: 32] = $urandom();
    end
  endtask

  // One clock: check grant, advance model at the edge, check registered outputs.
  task automatic step();
    int         g;
    logic [3:0] er;
    g  = model_pick();
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    cyc++;
    if (reset) begin
      q_idx.delete(); q_res.delete(); q_cnt.delete();
      m_last = NUM_REQ - 1;
      exp_rv = '0;
      exp_rd = '0;
    end else begin
      exp_rv = '0;
      if (!hold) begin
        foreach (q_cnt[i]) q_cnt[i]++;
        if (q_cnt.size() > 0 && q_cnt[0] == LAT + 1) begin
          exp_rv = 4'(1 << q_idx[0]);
          exp_rd = q_res[0];
          void'(q_idx.pop_front());
          void'(q_res.pop_front());
          void'(q_cnt.pop_front());
        end
        if (g >= 0) begin
          q_idx.push_back(g);
          q_res.push_back(fu_op(req_dataa[32*g +: 32], req_datab[32*g +: 32]));
          q_cnt.push_back(0);
          m_last = g;
        end
      end
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_data", rsp_data, exp_rd);
    chk("in_flight", 32'(in_flight), 32'(q_idx.size()));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'b0000);
    step();
    step();
  endtask

  typedef struct {
    logic       hold;
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;

  vec_t        vecs [12];
  int          t0;
  int          rt [$];
  logic [3:0]  rv [$];
  int          peak;
  int          lat_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Grant table starting from reset (pointer at NUM_REQ-1).
    vecs[0]  = '{1'b0, 4'b0001, 4'b0001};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0010};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0000};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0100};
    vecs[4]  = '{1'b0, 4'b1010, 4'b1000};
    vecs[5]  = '{1'b0, 4'b1010, 4'b0010};
    vecs[6]  = '{1'b0, 4'b1010, 4'b1000};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0101, 4'b0001};
    vecs[9]  = '{1'b0, 4'b0101, 4'b0100};
    vecs[10] = '{1'b0, 4'b0001, 4'b0001};
    vecs[11] = '{1'b0, 4'b1000, 4'b1000};

    m_last = NUM_REQ - 1;
    exp_rv = '0;
    exp_rd = '0;
    do_reset();
    chk("reset_in_flight", 32'(in_flight), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].hold, vecs[i].valid);
      #1;
      chk($sformatf("tbl_ready_%0d", i), 32'(req_ready), 32'(vecs[i].ready));
      step();
    end

    // Single op: latency and result value.
    do_reset();
    t0 = cyc;
    drive(1'b0, 1'b0, 4'b0001);
    req_dataa[31:0] = 32'h3F80_0000;
    req_datab[31:0] = 32'h4000_0000;
    step();
    chk("single_in_flight_1", 32'(in_flight), 32'd1);
    lat_seen = -1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 4'b0000);
      step();
      if (rsp_valid != 0 && lat_seen < 0) begin
        lat_seen = cyc - t0;
        chk("single_rsp_idx", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data", rsp_data, 32'h7F80_0000);
      end
    end
    chk("single_latency", 32'(lat_seen), 32'd7);
    chk("single_in_flight_0", 32'(in_flight), 32'd0);

    // All four valid for 8 cycles: rotation, ordered back-to-back returns, peak 6.
    do_reset();
    t0 = cyc; rt.delete(); rv.delete(); peak = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, (i < 8) ? 4'b1111 : 4'b0000);
      if (i < 8) begin
        #1;
        chk("rot_grant", 32'(req_ready), 32'(1 << (i % 4)));
      end
      step();
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (rsp_valid != 0) begin rt.push_back(cyc - t0); rv.push_back(rsp_valid); end
    end
    chk("rot_peak", 32'(peak), 32'd6);
    chk("rot_count", 32'(rt.size()), 32'd8);
    foreach (rt[i]) begin
      chk("rot_time", 32'(rt[i]), 32'(7 + i));
      chk("rot_idx", 32'(rv[i]), 32'(1 << (i % 4)));
    end

    // Three ops in flight, then three hold cycles: each return slips by 3.
    do_reset();
    t0 = cyc; rt.delete(); rv.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, (i >= 4 && i <= 6), (i < 3) ? 4'b0111 : 4'b0000);
      step();
      if (rsp_valid != 0) begin rt.push_back(cyc - t0); rv.push_back(rsp_valid); end
    end
    chk("hold_count", 32'(rt.size()), 32'd3);
    foreach (rt[i]) begin
      chk("hold_time", 32'(rt[i]), 32'(10 + i));
      chk("hold_idx", 32'(rv[i]), 32'(1 << i));
    end

    // Only requesters 1 and 3 valid: strict alternation.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 4'b1010);
      #1;
      chk("alt_grant", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
      step();
    end

    // Reset with four ops in flight: nothing returns, pointer back to 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'b1111);
      step();
    end
    drive(1'b1, 1'b0, 4'b1111);
    step();
    rt.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'b0000);
      step();
      if (rsp_valid != 0) rt.push_back(cyc);
    end
    chk("rst_no_rsp", 32'(rt.size()), 32'd0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    drive(1'b0, 1'b0, 4'b1111);
    #1;
    chk("rst_grant0", 32'(req_ready), 32'h1);
    step();

    // Randomized traffic with holds and occasional resets.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 4) == 0), 4'($urandom()));
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 4'b0000);
      step();
    end
    chk("drain_in_flight", 32'(in_flight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
